// File: rtl/aes_block_dma_if.sv
// Wishbone master/slave bundle used between the AES block DMA and the shared word memory.
interface aes_block_dma_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat_w;
    logic [3:0]        sel;
    logic [31:0]       dat_r;
    logic              ack;
    logic              err;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack, err
    );
endinterface

// File: rtl/aes_block_dma.sv
// AES block DMA: reads 4 words per block over Wishbone, hands the 128-bit block to the AES
// core, takes the 128-bit result back and writes it out as 4 words, repeated len_i times.
module aes_block_dma #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              port0_wb_clk_i,
    input  logic              port0_wb_rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    aes_block_dma_if.master   m_wb,
    output logic [127:0]      blk_o,
    output logic              blk_valid_o,
    input  logic              blk_ready_i,
    input  logic [127:0]      res_i,
    input  logic              res_valid_i,
    output logic              res_ready_o
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] BLK_OUT = 3'd3;
    localparam logic [2:0] RES_IN  = 3'd4;
    localparam logic [2:0] WR_REQ  = 3'd5;
    localparam logic [2:0] WR_WAIT = 3'd6;
    localparam logic [2:0] FINISH  = 3'd7;

    // Last wait-cycle count before giving up on an ack.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  remain;
    logic [1:0]        word_idx;
    logic [7:0]        tmo_cnt;
    logic [127:0]      blk;
    logic [127:0]      res;
    logic              zero_done;
    logic              err_pulse;
    logic              in_wait;
    logic              ack_ok;
    logic              abort;
    logic              last_word;
    logic              launch;
    logic              is_wr;
    logic [31:0]       res_word;

    // Alignment bits of the addresses are dropped on purpose.
    logic unused_low;
    assign unused_low = ^{src_addr_i[3:0], dst_addr_i[3:0]};

    assign in_wait   = (state == RD_WAIT) || (state == WR_WAIT);
    // err beats ack; ack beats a timeout landing in the same cycle.
    assign ack_ok    = in_wait && m_wb.ack && !m_wb.err;
    assign abort     = in_wait && (m_wb.err || (!m_wb.ack && (tmo_cnt == TMO_LAST)));
    assign last_word = (word_idx == 2'd3);
    assign launch    = (state == IDLE) && start_i && (len_i != '0);
    assign is_wr     = (state == WR_REQ) || (state == WR_WAIT);

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch) state_next = RD_REQ;
            RD_REQ:  state_next = RD_WAIT;
            RD_WAIT: begin
                if (abort)       state_next = IDLE;
                else if (ack_ok) state_next = last_word ? BLK_OUT : RD_REQ;
            end
            BLK_OUT: if (blk_ready_i) state_next = RES_IN;
            RES_IN:  if (res_valid_i) state_next = WR_REQ;
            WR_REQ:  state_next = WR_WAIT;
            WR_WAIT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (ack_ok) begin
                    if (!last_word)                 state_next = WR_REQ;
                    else if (remain == LEN_W'(1))   state_next = FINISH;
                    else                            state_next = RD_REQ;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge port0_wb_clk_i or posedge port0_wb_rst_i) begin
        if (port0_wb_rst_i) state <= IDLE;
        else                state <= state_next;
    end

    // Addresses, counters, block/result buffers and the done/err pulse registers.
    always_ff @(posedge port0_wb_clk_i or posedge port0_wb_rst_i) begin
        if (port0_wb_rst_i) begin
            src       <= '0;
            dst       <= '0;
            remain    <= '0;
            word_idx  <= '0;
            tmo_cnt   <= '0;
            blk       <= '0;
            res       <= '0;
            zero_done <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            zero_done <= (state == IDLE) && start_i && (len_i == '0);
            err_pulse <= abort;

            if (launch) begin
                src      <= {src_addr_i[ADDR_W-1:4], 4'h0};
                dst      <= {dst_addr_i[ADDR_W-1:4], 4'h0};
                remain   <= len_i;
                word_idx <= '0;
            end

            if ((state == RD_REQ) || (state == WR_REQ)) begin
                tmo_cnt <= '0;
            end else if (in_wait && !m_wb.ack && !abort) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end

            if ((state == RD_WAIT) && ack_ok) begin
                case (word_idx)
                    2'd0:    blk[127:96] <= m_wb.dat_r;
                    2'd1:    blk[95:64]  <= m_wb.dat_r;
                    2'd2:    blk[63:32]  <= m_wb.dat_r;
                    default: blk[31:0]   <= m_wb.dat_r;
                endcase
                word_idx <= word_idx + 2'd1;
            end

            if ((state == RES_IN) && res_valid_i) begin
                res <= res_i;
            end

            if ((state == WR_WAIT) && ack_ok) begin
                word_idx <= word_idx + 2'd1;
                if (last_word) begin
                    src    <= src + ADDR_W'(16);
                    dst    <= dst + ADDR_W'(16);
                    remain <= remain - LEN_W'(1);
                end
            end
        end
    end

    // Bus and handshake outputs decoded from the state; all zero while idle.
    always_comb begin
        case (word_idx)
            2'd0:    res_word = res[127:96];
            2'd1:    res_word = res[95:64];
            2'd2:    res_word = res[63:32];
            default: res_word = res[31:0];
        endcase
        m_wb.cyc   = (state == RD_REQ) || (state == RD_WAIT) || is_wr;
        m_wb.stb   = (state == RD_REQ) || (state == WR_REQ);
        m_wb.we    = is_wr;
        m_wb.sel   = m_wb.stb ? 4'hF : 4'h0;
        m_wb.adr   = '0;
        if (m_wb.cyc) m_wb.adr = (is_wr ? dst : src) + ADDR_W'({word_idx, 2'b00});
        m_wb.dat_w = is_wr ? res_word : 32'h0;
        blk_o       = blk;
        blk_valid_o = (state == BLK_OUT);
        res_ready_o = (state == RES_IN);
        busy_o      = (state != IDLE);
        done_o      = zero_done || (state == FINISH);
        err_o       = err_pulse;
    end

endmodule

// File: tb/tb_aes_block_dma.sv
// Randomized bench for aes_block_dma: word-memory slave, AES core stand-in and a
// transfer-level reference model of what each launch should read, hand over and write.
module tb_aes_block_dma;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   src_addr;
    logic [31:0]   dst_addr;
    logic [15:0]   len;
    logic          busy, done, err;
    logic [127:0]  blk;
    logic          blk_valid;
    logic          blk_ready = 1'b0;
    logic [127:0]  res = '0;
    logic          res_valid = 1'b0;
    logic          res_ready;

    always #5 clk = ~clk;

    aes_block_dma_if #(.ADDR_W(32)) wb ();

    aes_block_dma #(.ADDR_W(32), .LEN_W(16), .TIMEOUT(255)) dut (
        .port0_wb_clk_i (clk),
        .port0_wb_rst_i (rst),
        .start_i        (start),
        .src_addr_i     (src_addr),
        .dst_addr_i     (dst_addr),
        .len_i          (len),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .m_wb           (wb),
        .blk_o          (blk),
        .blk_valid_o    (blk_valid),
        .blk_ready_i    (blk_ready),
        .res_i          (res),
        .res_valid_i    (res_valid),
        .res_ready_o    (res_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Word memory, byte-addressed by word.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor state (sampled at negedge).
    logic [31:0]  rd_adr_q[$];
    logic [31:0]  wr_adr_q[$];
    logic [127:0] blk_q[$];
    int cycle = 0, stb_cnt = 0, cyc_cnt = 0, done_cnt = 0, err_cnt = 0;
    int err_cyc = 0, first_stb_cyc = 0, cyc_at_err = 0, unstable = 0, sel_bad = 0;
    logic         prev_valid = 1'b0;
    logic [127:0] prev_blk = '0;

    // Slave knobs.
    int err_on_read = 0;
    bit no_ack = 1'b0;

    // Memory slave: registered response the cycle after stb.
    always @(posedge clk) begin
        wb.ack <= 1'b0;
        wb.err <= 1'b0;
        if (wb.cyc && wb.stb && !no_ack) begin
            if (!wb.we && err_on_read != 0 && rd_adr_q.size() == err_on_read) begin
                wb.err <= 1'b1;
            end else begin
                wb.ack <= 1'b1;
                if (wb.we) mem[wb.adr] = wb.dat_w;
                else       wb.dat_r <= mem_rd(wb.adr);
            end
        end
    end

    // AES core stand-in: stalls blk_ready, returns blk ^ key.
    logic [127:0] key = '0;
    int stall = 0;
    int stall_cnt = 0;
    always @(posedge clk) begin
        if (blk_valid && !blk_ready) begin
            stall_cnt <= stall_cnt + 1;
            blk_ready <= (stall_cnt >= stall);
        end else begin
            stall_cnt <= 0;
            blk_ready <= 1'b0;
        end
        if (blk_valid && blk_ready) begin
            res_valid <= 1'b1;
            res       <= blk ^ key;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // Bus and strobe monitor.
    always @(negedge clk) begin
        cycle++;
        if (wb.stb) begin
            if (stb_cnt == 0) first_stb_cyc = cycle;
            stb_cnt++;
            if (wb.sel != 4'hF) sel_bad++;
            if (wb.we) wr_adr_q.push_back(wb.adr);
            else       rd_adr_q.push_back(wb.adr);
        end
        if (wb.cyc) cyc_cnt++;
        if (done) done_cnt++;
        if (err) begin
            err_cnt++;
            err_cyc = cycle;
            if (wb.cyc) cyc_at_err++;
        end
        if (blk_valid && prev_valid && blk != prev_blk) unstable++;
        if (blk_valid && blk_ready) blk_q.push_back(blk);
        prev_valid = blk_valid;
        prev_blk   = blk;
    end

    // Reference expectations for one launch.
    logic [31:0]  exp_rd_q[$];
    logic [31:0]  exp_wr_q[$];
    logic [31:0]  exp_wdat_q[$];
    logic [127:0] exp_blk_q[$];

    task automatic build_expect(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0]  sb, db;
        logic [127:0] b, r;
        exp_rd_q.delete(); exp_wr_q.delete(); exp_wdat_q.delete(); exp_blk_q.delete();
        sb = s & 32'hFFFF_FFF0;
        db = d & 32'hFFFF_FFF0;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 4; j++) exp_rd_q.push_back(sb + 32'(16 * k + 4 * j));
            b = {mem_rd(exp_rd_q[4*k]), mem_rd(exp_rd_q[4*k+1]),
                 mem_rd(exp_rd_q[4*k+2]), mem_rd(exp_rd_q[4*k+3])};
            exp_blk_q.push_back(b);
            r = b ^ key;
            for (int j = 0; j < 4; j++) begin
                exp_wr_q.push_back(db + 32'(16 * k + 4 * j));
                exp_wdat_q.push_back(r[127 - 32 * j -: 32]);
            end
        end
    endtask

    task automatic fill(input logic [31:0] base, input int n);
        for (int i = 0; i < 4 * n; i++) mem[base + 32'(4 * i)] = $urandom;
    endtask

    task automatic mon_clear();
        rd_adr_q.delete(); wr_adr_q.delete(); blk_q.delete();
        stb_cnt = 0; cyc_cnt = 0; done_cnt = 0; err_cnt = 0;
        cyc_at_err = 0; unstable = 0; sel_bad = 0;
    endtask

    // Called at negedge+1; start is seen by exactly one rising edge.
    task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        mon_clear();
        start = 1'b1; src_addr = s; dst_addr = d; len = n;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    int busy_low = 0;
    task automatic wait_end(input string tag, input int budget, input bit want_busy);
        bit seen = 1'b0;
        busy_low = 0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt + err_cnt > 0) begin
                seen = 1'b1;
                break;
            end
            if (want_busy && !busy) busy_low++;
            @(negedge clk); #1;
        end
        check_eq({tag, ".end_seen"}, seen, 1'b1);
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic verify(input string tag, input int n);
        check_eq({tag, ".n_rd"}, rd_adr_q.size(), exp_rd_q.size());
        for (int i = 0; i < exp_rd_q.size() && i < rd_adr_q.size(); i++)
            check_eq($sformatf("%s.rd_adr[%0d]", tag, i), rd_adr_q[i], exp_rd_q[i]);
        check_eq({tag, ".n_wr"}, wr_adr_q.size(), exp_wr_q.size());
        for (int i = 0; i < exp_wr_q.size() && i < wr_adr_q.size(); i++)
            check_eq($sformatf("%s.wr_adr[%0d]", tag, i), wr_adr_q[i], exp_wr_q[i]);
        check_eq({tag, ".n_blk"}, blk_q.size(), exp_blk_q.size());
        for (int i = 0; i < exp_blk_q.size() && i < blk_q.size(); i++)
            check_eq($sformatf("%s.blk[%0d]", tag, i), blk_q[i], exp_blk_q[i]);
        for (int i = 0; i < exp_wr_q.size(); i++)
            check_eq($sformatf("%s.mem[%h]", tag, exp_wr_q[i]), mem_rd(exp_wr_q[i]),
                     exp_wdat_q[i]);
        check_eq({tag, ".stb_cnt"}, stb_cnt, 8 * n);
        check_eq({tag, ".done_cnt"}, done_cnt, 1);
        check_eq({tag, ".err_cnt"}, err_cnt, 0);
        check_eq({tag, ".blk_stable"}, unstable, 0);
        check_eq({tag, ".sel"}, sel_bad, 0);
        check_eq({tag, ".busy_gap"}, busy_low, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst.busy", busy, 1'b0);
        check_eq("rst.done", done, 1'b0);
        check_eq("rst.err", err, 1'b0);
        check_eq("rst.cyc", wb.cyc, 1'b0);
        check_eq("rst.stb", wb.stb, 1'b0);
        check_eq("rst.blk_valid", blk_valid, 1'b0);
        check_eq("rst.res_ready", res_ready, 1'b0);
        check_eq("rst.blk", blk, 128'h0);
        rst = 1'b0;
        @(negedge clk); #1;

        // Single block with the fixed words and result.
        mem[32'h100] = 32'h00112233; mem[32'h104] = 32'h44556677;
        mem[32'h108] = 32'h8899AABB; mem[32'h10C] = 32'hCCDDEEFF;
        key = 128'h00112233_44556677_8899AABB_CCDDEEFF ^ 128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4;
        stall = 0;
        build_expect(32'h100, 32'h200, 1);
        kick(32'h100, 32'h200, 16'd1);
        wait_end("single", 200, 1'b1);
        verify("single", 1);
        check_eq("single.blk_const", blk_q.size() > 0 ? blk_q[0] : 128'h0,
                 128'h00112233_44556677_8899AABB_CCDDEEFF);
        check_eq("single.mem200", mem_rd(32'h200), 32'hA1A2A3A4);
        check_eq("single.mem20C", mem_rd(32'h20C), 32'hD1D2D3D4);

        // Three blocks with core backpressure.
        fill(32'h1000, 3);
        key = rand128();
        stall = 5;
        build_expect(32'h1000, 32'h2000, 3);
        kick(32'h1000, 32'h2000, 16'd3);
        wait_end("multi", 500, 1'b1);
        verify("multi", 3);
        stall = 0;

        // Zero length: done pulse, no bus activity, never busy.
        kick(32'h100, 32'h200, 16'd0);
        wait_end("zero", 20, 1'b0);
        check_eq("zero.done_cnt", done_cnt, 1);
        check_eq("zero.cyc_cnt", cyc_cnt, 0);
        check_eq("zero.busy", busy, 1'b0);

        // Second start while busy must not disturb the running transfer.
        fill(32'h3000, 2);
        fill(32'h5000, 7);
        key = rand128();
        build_expect(32'h3000, 32'h4000, 2);
        kick(32'h3000, 32'h4000, 16'd2);
        repeat (6) @(negedge clk);
        #1;
        check_eq("bstart.busy", busy, 1'b1);
        start = 1'b1; src_addr = 32'h5000; dst_addr = 32'h6000; len = 16'd7;
        @(negedge clk); #1;
        start = 1'b0;
        wait_end("bstart", 400, 1'b1);
        verify("bstart", 2);

        // Unaligned source that wraps past the top of the address space.
        fill(32'hFFFF_FFF0, 1);
        fill(32'h0000_0000, 1);
        key = rand128();
        build_expect(32'hFFFF_FFF7, 32'h7000, 2);
        kick(32'hFFFF_FFF7, 32'h7000, 16'd2);
        wait_end("wrap", 400, 1'b1);
        verify("wrap", 2);
        check_eq("wrap.first_rd", rd_adr_q.size() > 0 ? rd_adr_q[0] : 32'h1, 32'hFFFF_FFF0);
        check_eq("wrap.blk2_rd", rd_adr_q.size() > 4 ? rd_adr_q[4] : 32'h1, 32'h0);

        // Bus error on the third read.
        fill(32'hC000, 2);
        err_on_read = 3;
        kick(32'hC000, 32'hD000, 16'd2);
        wait_end("buserr", 200, 1'b1);
        err_on_read = 0;
        check_eq("buserr.err_cnt", err_cnt, 1);
        check_eq("buserr.done_cnt", done_cnt, 0);
        check_eq("buserr.n_rd", rd_adr_q.size(), 3);
        check_eq("buserr.n_wr", wr_adr_q.size(), 0);
        check_eq("buserr.cyc_at_err", cyc_at_err, 0);
        check_eq("buserr.busy", busy, 1'b0);

        // No ack at all: abort TIMEOUT wait cycles after the strobe, err one cycle later.
        no_ack = 1'b1;
        kick(32'hC000, 32'hD000, 16'd1);
        wait_end("tmo", 600, 1'b1);
        no_ack = 1'b0;
        check_eq("tmo.err_cnt", err_cnt, 1);
        check_eq("tmo.done_cnt", done_cnt, 0);
        check_eq("tmo.stb_cnt", stb_cnt, 1);
        check_eq("tmo.gap", err_cyc - first_stb_cyc, 256);
        check_eq("tmo.cyc_at_err", cyc_at_err, 0);

        // Reset while waiting on the second write of block 2.
        fill(32'h8000, 3);
        key = rand128();
        kick(32'h8000, 32'h9000, 16'd3);
        for (int i = 0; i < 400; i++) begin
            if (wr_adr_q.size() >= 6) break;
            @(negedge clk); #1;
        end
        check_eq("rstmid.reach", wr_adr_q.size() >= 6, 1'b1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_eq("rstmid.busy", busy, 1'b0);
        check_eq("rstmid.cyc", wb.cyc, 1'b0);
        check_eq("rstmid.we", wb.we, 1'b0);
        check_eq("rstmid.adr", wb.adr, 32'h0);
        check_eq("rstmid.dat_w", wb.dat_w, 32'h0);
        check_eq("rstmid.blk", blk, 128'h0);
        repeat (3) @(negedge clk);
        #1;
        check_eq("rstmid.done_cnt", done_cnt, 0);
        check_eq("rstmid.err_cnt", err_cnt, 0);
        rst = 1'b0;
        @(negedge clk); #1;
        fill(32'hA000, 1);
        key = rand128();
        build_expect(32'hA000, 32'hB000, 1);
        kick(32'hA000, 32'hB000, 16'd1);
        wait_end("after_rst", 200, 1'b1);
        verify("after_rst", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
